// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: request/ready handshake to data memory, byte-lane
// store formatting, load extraction/extension, and a pipeline stall while busy.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid_in,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_rs2_data,
    output logic        o_dm_req,
    output logic [3:0]  o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    input  logic        i_dm_ready,
    input  logic [31:0] i_dm_rdata,
    output logic [31:0] o_load_data,
    output logic        o_load_valid,
    output logic        o_store_done,
    output logic        o_err,
    output logic        o_stall
);

    localparam logic [2:0]  F3_B  = 3'b000;
    localparam logic [2:0]  F3_H  = 3'b001;
    localparam logic [2:0]  F3_W  = 3'b010;
    localparam logic [2:0]  F3_BU = 3'b100;
    localparam logic [2:0]  F3_HU = 3'b101;
    localparam logic [31:0] LP_TMO = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_cnt;
    logic [2:0]  r_f3;
    logic [1:0]  r_boff;
    logic        r_is_load;
    logic        r_req, r_load_valid, r_store_done, r_err;
    logic [3:0]  r_we;
    logic [31:0] r_addr, r_wdata, r_load_data;

    logic        w_access, w_is_load, w_legal, w_accept, w_illegal, w_timeout, w_stall;
    logic [3:0]  w_we;
    logic [31:0] w_wdata, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_is_load = i_mem_read;
    assign w_access  = i_valid_in && (i_mem_read || i_mem_write);
    assign w_timeout = (LP_TMO != 32'd0) && (r_cnt == LP_TMO - 32'd1);

    // Alignment and funct3 legality; unsigned widths only exist for loads.
    always_comb begin
        w_legal = 1'b0;
        case (i_funct3)
            F3_B:    w_legal = 1'b1;
            F3_H:    w_legal = ~i_alu_out[0];
            F3_W:    w_legal = (i_alu_out[1:0] == 2'b00);
            F3_BU:   w_legal = w_is_load;
            F3_HU:   w_legal = w_is_load && ~i_alu_out[0];
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_we    = 4'b0000;
        w_wdata = i_rs2_data;
        case (i_funct3)
            F3_B: begin
                w_we    = 4'b0001 << i_alu_out[1:0];
                w_wdata = {4{i_rs2_data[7:0]}};
            end
            F3_H: begin
                w_we    = 4'b0011 << {i_alu_out[1], 1'b0};
                w_wdata = {2{i_rs2_data[15:0]}};
            end
            default: begin
                w_we    = 4'b1111;
                w_wdata = i_rs2_data;
            end
        endcase
        if (w_is_load) w_we = 4'b0000;
    end

    always_comb begin
        w_byte = i_dm_rdata[{r_boff, 3'b000} +: 8];
        w_half = i_dm_rdata[{r_boff[1], 4'b0000} +: 16];
        case (r_f3)
            F3_B:    w_ext = {{24{w_byte[7]}}, w_byte};
            F3_H:    w_ext = {{16{w_half[15]}}, w_half};
            F3_BU:   w_ext = {24'd0, w_byte};
            F3_HU:   w_ext = {16'd0, w_half};
            default: w_ext = i_dm_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // DONE ignores inputs: upstream still shows the completed instruction.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_illegal = 1'b0;
        w_stall   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (w_legal) begin
                        w_accept = 1'b1;
                        w_stall  = 1'b1;
                        w_next   = S_BUSY;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (i_dm_ready || w_timeout) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt        <= '0;
            r_f3         <= '0;
            r_boff       <= '0;
            r_is_load    <= 1'b0;
            r_req        <= 1'b0;
            r_we         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_store_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_store_done <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req     <= 1'b1;
                        r_cnt     <= '0;
                        r_f3      <= i_funct3;
                        r_boff    <= i_alu_out[1:0];
                        r_is_load <= w_is_load;
                        r_addr    <= {i_alu_out[31:2], 2'b00};
                        r_we      <= w_we;
                        r_wdata   <= w_wdata;
                    end
                    if (w_illegal) r_err <= 1'b1;
                end
                S_BUSY: begin
                    // A ready in the final allowed cycle still completes normally.
                    if (i_dm_ready) begin
                        r_req <= 1'b0;
                        if (r_is_load) begin
                            r_load_data  <= w_ext;
                            r_load_valid <= 1'b1;
                        end else begin
                            r_store_done <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_req <= 1'b0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dm_req     = r_req;
    assign o_dm_we      = r_we;
    assign o_dm_addr    = r_addr;
    assign o_dm_wdata   = r_wdata;
    assign o_load_data  = r_load_data;
    assign o_load_valid = r_load_valid;
    assign o_store_done = r_store_done;
    assign o_err        = r_err;
    assign o_stall      = w_stall;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a scoreboard of expected completions is
// filled as each access is driven and drained as pulses come back.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, mem_read, mem_write, dm_ready;
    logic [2:0]  funct3;
    logic [31:0] alu_out, rs2_data, dm_rdata;
    logic        dm_req, load_valid, store_done, err, stall;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr, dm_wdata, load_data;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_valid_in(valid_in),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
        .i_alu_out(alu_out), .i_rs2_data(rs2_data),
        .o_dm_req(dm_req), .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata),
        .i_dm_ready(dm_ready), .i_dm_rdata(dm_rdata),
        .o_load_data(load_data), .o_load_valid(load_valid), .o_store_done(store_done),
        .o_err(err), .o_stall(stall)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } exp_t;

    localparam logic [1:0] K_LD = 2'd0, K_ST = 2'd1, K_ERR = 2'd2, K_MULTI = 2'd3;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int ns, nr, nl, nsd, ne, nc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drives one access, answers dm_ready on the rdy_at-th request cycle
    // (0 = never), holds the instruction while stall is high, and drains the
    // scoreboard on the completion pulse. Returns per-signal cycle counts.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rdata, input int rdy_at,
                             input logic [31:0] eaddr, input logic [3:0] ewe, input logic [31:0] ewd,
                             input logic [1:0] ekind, input logic [31:0] edata,
                             output int o_ns, output int o_nr, output int o_nl,
                             output int o_nsd, output int o_ne, output int o_nc);
        bit   done = 0;
        bit   hold;
        exp_t e, got;
        o_ns = 0; o_nr = 0; o_nl = 0; o_nsd = 0; o_ne = 0; o_nc = 0;
        valid_in = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_out = a; rs2_data = d; dm_rdata = rdata;
        e.kind = ekind; e.data = edata;
        sb.push_back(e);
        while (!done && o_nc < 16) begin
            #1;
            o_nc++;
            if (stall) o_ns++;
            if (dm_req) begin
                o_nr++;
                chk({tag, "_addr"}, dm_addr, eaddr);
                chk({tag, "_we"}, 32'(dm_we), 32'(ewe));
                chk({tag, "_wdata"}, dm_wdata, ewd);
            end
            if (load_valid) o_nl++;
            if (store_done) o_nsd++;
            if (err) o_ne++;
            if (load_valid || store_done || err) begin
                done = 1;
                got.kind = (32'(load_valid) + 32'(store_done) + 32'(err) > 1) ? K_MULTI :
                           load_valid ? K_LD : store_done ? K_ST : K_ERR;
                got.data = load_data;
                chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({tag, "_kind"}, 32'(got.kind), 32'(e.kind));
                    if (e.kind == K_LD) chk({tag, "_load_data"}, got.data, e.data);
                end
            end
            dm_ready = dm_req && (rdy_at != 0) && (o_nr == rdy_at);
            hold = stall;
            step();
            dm_ready = 1'b0;
            if (!hold) valid_in = 1'b0;
        end
        chk({tag, "_responded"}, 32'(done), 32'd1);
        #1;
        chk({tag, "_post_req"}, 32'(dm_req), 32'd0);
        chk({tag, "_post_pulses"}, {29'd0, load_valid, store_done, err}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; alu_out = '0; rs2_data = '0; dm_ready = 1'b0; dm_rdata = '0;
        repeat (3) step();
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_we", 32'(dm_we), 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_ldata", load_data, 32'd0);
        chk("rst_pulses", {29'd0, load_valid, store_done, err}, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        step();

        // LB, sign-extended top byte, ready in first BUSY cycle
        do_access("lb", 1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_0000, 1,
                  32'h1000, 4'b0000, 32'h0, K_LD, 32'hFFFF_FF80, ns, nr, nl, nsd, ne, nc);
        chk("lb_stall_cycles", 32'(ns), 32'd2);
        chk("lb_req_cycles", 32'(nr), 32'd1);
        chk("lb_lv_count", 32'(nl), 32'd1);
        chk("lb_total_cycles", 32'(nc), 32'd3);

        // SH upper half, ready delayed 3 cycles
        do_access("sh", 0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 4,
                  32'h2000, 4'b1100, 32'hABCD_ABCD, K_ST, 32'h0, ns, nr, nl, nsd, ne, nc);
        chk("sh_req_cycles", 32'(nr), 32'd4);
        chk("sh_sd_count", 32'(nsd), 32'd1);
        chk("sh_lv_count", 32'(nl), 32'd0);

        // Illegal accesses: no request, err next cycle, no stall
        do_access("lw_mis", 1, 0, 3'b010, 32'h3001, 32'h0, 32'h0, 1,
                  32'h0, 4'b0, 32'h0, K_ERR, 32'h0, ns, nr, nl, nsd, ne, nc);
        chk("lw_mis_stall", 32'(ns), 32'd0);
        chk("lw_mis_req", 32'(nr), 32'd0);
        chk("lw_mis_cycles", 32'(nc), 32'd2);
        do_access("f3_011", 1, 0, 3'b011, 32'h3000, 32'h0, 32'h0, 1,
                  32'h0, 4'b0, 32'h0, K_ERR, 32'h0, ns, nr, nl, nsd, ne, nc);
        chk("f3_011_stall", 32'(ns), 32'd0);
        chk("f3_011_req", 32'(nr), 32'd0);
        do_access("sbu", 0, 1, 3'b100, 32'h3000, 32'h77, 32'h0, 1,
                  32'h0, 4'b0, 32'h0, K_ERR, 32'h0, ns, nr, nl, nsd, ne, nc);
        chk("sbu_req", 32'(nr), 32'd0);

        // Back-to-back LHU then LW, 3 cycles each
        do_access("lhu", 1, 0, 3'b101, 32'h0, 32'h0, 32'hCAFE_9876, 1,
                  32'h0, 4'b0000, 32'h0, K_LD, 32'h0000_9876, ns, nr, nl, nsd, ne, nc);
        chk("lhu_cycles", 32'(nc), 32'd3);
        do_access("lw", 1, 0, 3'b010, 32'h4, 32'h0, 32'h1234_5678, 1,
                  32'h4, 4'b0000, 32'h0, K_LD, 32'h1234_5678, ns, nr, nl, nsd, ne, nc);
        chk("lw_cycles", 32'(nc), 32'd3);
        chk("lw_req_cycles", 32'(nr), 32'd1);

        // Remaining width/extension/lane cases
        do_access("lh", 1, 0, 3'b001, 32'h6, 32'h0, 32'h8001_0000, 2,
                  32'h4, 4'b0000, 32'h0, K_LD, 32'hFFFF_8001, ns, nr, nl, nsd, ne, nc);
        do_access("lbu", 1, 0, 3'b100, 32'h5, 32'h0, 32'h0000_F000, 1,
                  32'h4, 4'b0000, 32'h0, K_LD, 32'h0000_00F0, ns, nr, nl, nsd, ne, nc);
        do_access("sb", 0, 1, 3'b000, 32'h3, 32'h0000_00AB, 32'h0, 2,
                  32'h0, 4'b1000, 32'hABAB_ABAB, K_ST, 32'h0, ns, nr, nl, nsd, ne, nc);
        chk("sb_sd_count", 32'(nsd), 32'd1);

        // Timeout with TIMEOUT_CYCLES=4
        do_access("tmo", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD_0000, 0,
                  32'h10, 4'b0000, 32'h0, K_ERR, 32'h0, ns, nr, nl, nsd, ne, nc);
        chk("tmo_req_cycles", 32'(nr), 32'd4);
        chk("tmo_err_count", 32'(ne), 32'd1);
        chk("tmo_lv_count", 32'(nl), 32'd0);
        chk("tmo_cycles", 32'(nc), 32'd6);

        // Asynchronous reset in the middle of BUSY
        valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
        alu_out = 32'h100; rs2_data = 32'h55; dm_ready = 1'b0;
        step();
        step();
        #1;
        chk("mid_busy_req", 32'(dm_req), 32'd1);
        rst_n = 1'b0; valid_in = 1'b0; mem_write = 1'b0;
        #1;
        chk("arst_req", 32'(dm_req), 32'd0);
        chk("arst_we", 32'(dm_we), 32'd0);
        chk("arst_addr", dm_addr, 32'd0);
        chk("arst_wdata", dm_wdata, 32'd0);
        chk("arst_ldata", load_data, 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        do_access("sw_after_rst", 0, 1, 3'b010, 32'h44, 32'hDEAD_BEEF, 32'h0, 2,
                  32'h44, 4'b1111, 32'hDEAD_BEEF, K_ST, 32'h0, ns, nr, nl, nsd, ne, nc);
        chk("sw_after_rst_sd", 32'(nsd), 32'd1);
        chk("sw_after_rst_req", 32'(nr), 32'd2);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
